// File: rtl/turnstile_multi_pass.sv
// Coin-operated turnstile controller: banks prepaid passes, relocks after an
// idle timeout and raises a timed alarm on a forced push while locked.
module turnstile_multi_pass #(
  parameter int PRICE          = 2,
  parameter int MAX_PASSES     = 3,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int ALARM_CYCLES   = 4,
  localparam int PASS_W        = $clog2(MAX_PASSES + 1),
  localparam int COIN_W        = $clog2(PRICE + 1)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Coin,
  input  logic              i_Push,
  output logic              o_Locked,
  output logic [PASS_W-1:0] o_Passes,
  output logic [COIN_W-1:0] o_Coins,
  output logic              o_Coin_Reject,
  output logic              o_Alarm,
  output logic              o_Timeout
);

  localparam int IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int ALARM_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  localparam logic [COIN_W-1:0]  COIN_LAST  = COIN_W'(PRICE - 1);
  localparam logic [PASS_W-1:0]  PASS_MAX   = PASS_W'(MAX_PASSES);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  =
    IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_CYCLES - 1);

  typedef enum logic [1:0] {
    LOCKED,
    UNLOCKED,
    ALARM
  } state_t;

  state_t              state, state_next;
  logic [PASS_W-1:0]   passes, passes_next, credited;
  logic [COIN_W-1:0]   coins, coins_next;
  logic [IDLE_W-1:0]   idle_timer, idle_next;
  logic [ALARM_W-1:0]  alarm_timer, alarm_next;
  logic                reject_q, reject_next;
  logic                timeout_q, timeout_next;
  logic                coin_full, pass_inc, quiet;

  // Coin accounting is identical in every state; rejection is judged on the
  // registered pass count, before any concurrent push decrement.
  always_comb begin
    coin_full   = (coins == COIN_LAST);
    pass_inc    = i_Coin && coin_full && (passes != PASS_MAX);
    reject_next = i_Coin && coin_full && (passes == PASS_MAX);
    coins_next  = coins;
    if (i_Coin && !coin_full) begin
      coins_next = coins + 1'b1;
    end else if (pass_inc) begin
      coins_next = '0;
    end
    credited = passes + PASS_W'(pass_inc);
  end

  always_comb begin
    state_next   = state;
    passes_next  = credited;
    idle_next    = '0;
    alarm_next   = '0;
    timeout_next = 1'b0;
    quiet        = !i_Coin && !i_Push;
    case (state)
      LOCKED: begin
        if (i_Push) begin
          state_next = ALARM;
        end else if (credited != '0) begin
          state_next = UNLOCKED;
        end
      end
      UNLOCKED: begin
        if (i_Push) begin
          passes_next = credited - 1'b1;
        end
        if (!quiet) begin
          if (passes_next == '0) begin
            state_next = LOCKED;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (idle_timer == IDLE_LAST)) begin
          passes_next  = '0;
          timeout_next = 1'b1;
          state_next   = LOCKED;
        end else if (TIMEOUT_CYCLES != 0) begin
          idle_next = idle_timer + 1'b1;
        end
      end
      ALARM: begin
        // A push while alarmed restarts the alarm window instead of passing.
        if (i_Push) begin
          alarm_next = '0;
        end else if (alarm_timer == ALARM_LAST) begin
          state_next = (credited != '0) ? UNLOCKED : LOCKED;
        end else begin
          alarm_next = alarm_timer + 1'b1;
        end
      end
      default: begin
        state_next  = LOCKED;
        passes_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= LOCKED;
      passes      <= '0;
      coins       <= '0;
      idle_timer  <= '0;
      alarm_timer <= '0;
      reject_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_next;
      passes      <= passes_next;
      coins       <= coins_next;
      idle_timer  <= idle_next;
      alarm_timer <= alarm_next;
      reject_q    <= reject_next;
      timeout_q   <= timeout_next;
    end
  end

  assign o_Locked      = (state != UNLOCKED);
  assign o_Alarm       = (state == ALARM);
  assign o_Passes      = passes;
  assign o_Coins       = coins;
  assign o_Coin_Reject = reject_q;
  assign o_Timeout     = timeout_q;

endmodule

// File: tb/tb_turnstile_multi_pass.sv
// Self-checking bench for turnstile_multi_pass: vector table, directed corner
// sequences and randomized traffic against a credit-based reference model.
module tb_turnstile_multi_pass;

  localparam int PRICE          = 2;
  localparam int MAX_PASSES     = 3;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int ALARM_CYCLES   = 4;
  localparam int CAP            = MAX_PASSES * PRICE + PRICE - 1;

  localparam int M_LOCKED   = 0;
  localparam int M_UNLOCKED = 1;
  localparam int M_ALARM    = 2;

  logic       clk, rst_n, coin, push;
  logic       locked, coin_reject, alarm, timeout;
  logic [1:0] passes, coins;

  int tests_run = 0;
  int failures  = 0;

  turnstile_multi_pass #(
    .PRICE(PRICE), .MAX_PASSES(MAX_PASSES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Coin(coin), .i_Push(push),
    .o_Locked(locked), .o_Passes(passes), .o_Coins(coins),
    .o_Coin_Reject(coin_reject), .o_Alarm(alarm), .o_Timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       coin;
    logic       push;
    logic       locked;
    logic [1:0] passes;
    logic [1:0] coins;
    logic       reject;
    logic       alarm;
    logic       timeout;
  } vec_t;

  vec_t vecs[12];

  // Reference model: total credit in coins, passes = credit / PRICE
  int m_credit, m_mode, m_quiet, m_elapsed;
  logic m_reject, m_timeout;

  task automatic model_reset();
    m_credit = 0; m_mode = M_LOCKED; m_quiet = 0; m_elapsed = 0;
    m_reject = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic p);
    m_reject  = c && (m_credit == CAP);
    m_timeout = 1'b0;
    if (c && !m_reject) m_credit++;
    case (m_mode)
      M_LOCKED: begin
        if (p) begin
          m_mode = M_ALARM; m_elapsed = 0;
        end else if (m_credit >= PRICE) begin
          m_mode = M_UNLOCKED; m_quiet = 0;
        end
      end
      M_UNLOCKED: begin
        if (p) m_credit -= PRICE;
        if (c || p) m_quiet = 0; else m_quiet++;
        if (TIMEOUT_CYCLES > 0 && m_quiet == TIMEOUT_CYCLES) begin
          m_credit  = m_credit % PRICE;
          m_timeout = 1'b1;
          m_mode    = M_LOCKED;
        end else if (m_credit < PRICE) begin
          m_mode = M_LOCKED;
        end
      end
      default: begin
        if (p) begin
          m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == ALARM_CYCLES) begin
            m_mode  = (m_credit >= PRICE) ? M_UNLOCKED : M_LOCKED;
            m_quiet = 0;
          end
        end
      end
    endcase
  endtask

  task automatic check_output(input string name, input logic e_locked,
                              input int e_passes, input int e_coins,
                              input logic e_reject, input logic e_alarm,
                              input logic e_timeout);
    logic [1:0] ep, ec;
    ep = 2'(e_passes);
    ec = 2'(e_coins);
    tests_run++;
    if (locked !== e_locked || passes !== ep || coins !== ec ||
        coin_reject !== e_reject || alarm !== e_alarm || timeout !== e_timeout) begin
      failures++;
      $display("[TB] FAIL %s: got locked=%b passes=%0d coins=%0d reject=%b alarm=%b timeout=%b, expected locked=%b passes=%0d coins=%0d reject=%b alarm=%b timeout=%b",
               name, locked, passes, coins, coin_reject, alarm, timeout,
               e_locked, ep, ec, e_reject, e_alarm, e_timeout);
    end
  endtask

  task automatic check_model(input string name);
    check_output(name, m_mode != M_UNLOCKED, m_credit / PRICE, m_credit % PRICE,
                 m_reject, m_mode == M_ALARM, m_timeout);
  endtask

  task automatic apply_stimulus(input logic c, input logic p);
    @(negedge clk);
    coin = c;
    push = p;
    @(posedge clk);
    #1;
    coin = 1'b0;
    push = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    coin  = 1'b0;
    push  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_reset();
  endtask

  // Drops reset between clock edges and checks outputs before the next edge
  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output(name, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    //             coin  push  lock  pass  coin  rej   alrm  tmo
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    coin  = 1'b0;
    push  = 1'b0;
    model_reset();
    #12;
    check_output("reset_state", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].coin, vecs[i].push);
      check_output($sformatf("vec%0d", i), vecs[i].locked, vecs[i].passes,
                   vecs[i].coins, vecs[i].reject, vecs[i].alarm, vecs[i].timeout);
    end

    // Saturation: credit caps at MAX_PASSES*PRICE + PRICE-1, extra coins rejected
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      int cr;
      cr = (i > CAP) ? CAP : i;
      apply_stimulus(1'b1, 1'b0);
      check_output($sformatf("sat_coin%0d", i), cr < PRICE, cr / PRICE, cr % PRICE,
                   i > CAP, 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 1'b1);
    check_output("sat_push1", 1'b0, 2, 1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    check_output("sat_push2", 1'b0, 1, 1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    check_output("sat_push3", 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);

    // Alarm window restarted by a second push
    do_reset();
    apply_stimulus(1'b0, 1'b1);
    check_output("alarm_enter", 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    check_output("alarm_cyc1", 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    check_output("alarm_repush", 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < ALARM_CYCLES - 1; i++) begin
      apply_stimulus(1'b0, 1'b0);
      check_output($sformatf("alarm_hold%0d", i), 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0);
    check_output("alarm_exit", 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    // Idle timeout, restarted by a coin on idle cycle 7
    do_reset();
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_output("to_unlock", 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(1'b0, 1'b0);
      check_output($sformatf("to_idle%0d", i), 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b1, 1'b0);
    check_output("to_coin7", 1'b0, 1, 1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
      apply_stimulus(1'b0, 1'b0);
      check_output($sformatf("to_reidle%0d", i), 1'b0, 1, 1, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0);
    check_output("to_fire", 1'b1, 0, 1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    check_output("to_after", 1'b1, 0, 1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-alarm and mid-unlocked
    do_reset();
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    check_output("pre_rst_alarm", 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    async_reset_check("rst_mid_alarm");
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0);
    check_output("pre_rst_unlocked", 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);
    async_reset_check("rst_mid_unlocked");

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic c, p;
      if ($urandom_range(399) == 0) begin
        do_reset();
        check_model("rand_reset");
      end
      c = ($urandom_range(99) < 18);
      p = ($urandom_range(99) < 10);
      apply_stimulus(c, p);
      model_step(c, p);
      check_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
